// File: rtl/apb2axi_rd_collector_if.sv
// AXI R-channel, AR-issue, RDF-push and CQ-push signals of the read collector.
// slave: collector side, master: the surrounding logic or a testbench.
interface apb2axi_rd_collector_if #(
    parameter int TAG_W        = 4,
    parameter int ID_W         = 4,
    parameter int DATA_W       = 64,
    parameter int COMPLETION_W = 16
);
    logic                    ar_issue_valid;
    logic [TAG_W-1:0]        ar_issue_tag;
    logic [7:0]              ar_issue_len;
    logic                    rvalid;
    logic                    rready;
    logic [ID_W-1:0]         rid;
    logic [DATA_W-1:0]       rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rdf_push_valid;
    logic [TAG_W-1:0]        rdf_push_tag;
    logic [DATA_W-1:0]       rdf_push_data;
    logic [1:0]              rdf_push_resp;
    logic                    rdf_push_last;
    logic                    rdf_push_ready;
    logic                    cq_push_valid;
    logic [COMPLETION_W-1:0] cq_push_data;
    logic                    cq_push_ready;

    modport slave (
        input  ar_issue_valid, ar_issue_tag, ar_issue_len,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready,
        output rdf_push_valid, rdf_push_tag, rdf_push_data,
        output rdf_push_resp, rdf_push_last,
        input  rdf_push_ready,
        output cq_push_valid, cq_push_data,
        input  cq_push_ready
    );

    modport master (
        output ar_issue_valid, ar_issue_tag, ar_issue_len,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready,
        input  rdf_push_valid, rdf_push_tag, rdf_push_data,
        input  rdf_push_resp, rdf_push_last,
        output rdf_push_ready,
        input  cq_push_valid, cq_push_data,
        output cq_push_ready
    );
endinterface

// File: rtl/apb2axi_rd_collector.sv
// AXI read-return collector: per-beat RDF push, per-burst CQ completion.
// Optional APB2AXI_RD_STATS_EN adds stat_beats / stat_drops counters.
module apb2axi_rd_collector #(
    parameter int TAG_W        = 4,
    parameter int ID_W         = 4,
    parameter int DATA_W       = 64,
    parameter int COMPLETION_W = 16
) (
    input  logic aclk,
    input  logic areset,
    apb2axi_rd_collector_if.slave bus,
    output logic err_unexpected,
    output logic err_len
`ifdef APB2AXI_RD_STATS_EN
    ,
    output logic [31:0] stat_beats,
    output logic [15:0] stat_drops
`endif
);
    localparam int N_TAG = 1 << TAG_W;
    localparam int PK_W  = TAG_W + 12;

    logic             pend_q  [N_TAG];
    logic             pend_d  [N_TAG];
    logic [7:0]       exp_q   [N_TAG];
    logic [7:0]       exp_d   [N_TAG];
    logic [7:0]       cnt_q   [N_TAG];
    logic [7:0]       cnt_d   [N_TAG];
    logic [1:0]       worst_q [N_TAG];
    logic [1:0]       worst_d [N_TAG];
    logic             err_q   [N_TAG];
    logic             err_d   [N_TAG];

    logic                    en_q, en_d;
    logic                    rdf_v_q, rdf_v_d;
    logic [TAG_W-1:0]        rdf_tag_q, rdf_tag_d;
    logic [DATA_W-1:0]       rdf_data_q, rdf_data_d;
    logic [1:0]              rdf_resp_q, rdf_resp_d;
    logic                    rdf_last_q, rdf_last_d;
    logic                    cq_v_q, cq_v_d;
    logic [COMPLETION_W-1:0] cq_data_q, cq_data_d;
    logic                    eu_q, eu_d;
    logic                    el_q, el_d;

    logic             rready;
    logic [TAG_W-1:0] t;
    logic             acc, drop, take;
    logic             at_exp, fin, len_bad;
    logic [1:0]       merged;
    logic [PK_W-1:0]  pk;

    // Ready depends only on registered state and downstream readies;
    // en_q keeps it low while in reset and for the first cycle after.
    assign rready = en_q && (!rdf_v_q || bus.rdf_push_ready)
                    && !(cq_v_q && !bus.cq_push_ready);

    assign t       = bus.rid[TAG_W-1:0];
    assign acc     = bus.rvalid && rready;
    assign drop    = acc && !pend_q[t];
    assign take    = acc && pend_q[t];
    assign at_exp  = (cnt_q[t] == exp_q[t]);
    assign fin     = bus.rlast || at_exp;
    assign len_bad = (bus.rlast != at_exp);
    assign merged  = (bus.rresp > worst_q[t]) ? bus.rresp : worst_q[t];

    // Next state: beat handling first, then AR issue so a same-cycle
    // close on the issued tag frees it before the fresh load.
    always_comb begin
        pend_d     = pend_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        worst_d    = worst_q;
        err_d      = err_q;
        en_d       = 1'b1;
        rdf_v_d    = rdf_v_q;
        rdf_tag_d  = rdf_tag_q;
        rdf_data_d = rdf_data_q;
        rdf_resp_d = rdf_resp_q;
        rdf_last_d = rdf_last_q;
        cq_v_d     = cq_v_q;
        cq_data_d  = cq_data_q;
        eu_d       = eu_q;
        el_d       = el_q;
        pk         = '0;

        if (rdf_v_q && bus.rdf_push_ready) rdf_v_d = 1'b0;
        if (cq_v_q && bus.cq_push_ready) cq_v_d = 1'b0;
        if (drop) eu_d = 1'b1;

        if (take) begin
            rdf_v_d    = 1'b1;
            rdf_tag_d  = t;
            rdf_data_d = bus.rdata;
            rdf_resp_d = bus.rresp;
            rdf_last_d = fin;
            err_d[t]   = err_q[t] | len_bad;
            if (len_bad) el_d = 1'b1;
            if (fin) begin
                pk = {t, 1'b0, merged,
                      err_q[t] | len_bad | merged[1],
                      cnt_q[t] + 8'd1};
                cq_v_d     = 1'b1;
                cq_data_d  = COMPLETION_W'(pk);
                pend_d[t]  = 1'b0;
                cnt_d[t]   = 8'd0;
                worst_d[t] = 2'd0;
                err_d[t]   = 1'b0;
            end else begin
                if (cnt_q[t] != 8'hFF) cnt_d[t] = cnt_q[t] + 8'd1;
                worst_d[t] = merged;
            end
        end

        if (bus.ar_issue_valid) begin
            if (pend_d[bus.ar_issue_tag]) begin
                eu_d = 1'b1;
            end else begin
                pend_d[bus.ar_issue_tag]  = 1'b1;
                exp_d[bus.ar_issue_tag]   = bus.ar_issue_len;
                cnt_d[bus.ar_issue_tag]   = 8'd0;
                worst_d[bus.ar_issue_tag] = 2'd0;
                err_d[bus.ar_issue_tag]   = 1'b0;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < N_TAG; i++) begin
                pend_q[i]  <= 1'b0;
                exp_q[i]   <= 8'd0;
                cnt_q[i]   <= 8'd0;
                worst_q[i] <= 2'd0;
                err_q[i]   <= 1'b0;
            end
            en_q       <= 1'b0;
            rdf_v_q    <= 1'b0;
            rdf_tag_q  <= '0;
            rdf_data_q <= '0;
            rdf_resp_q <= 2'd0;
            rdf_last_q <= 1'b0;
            cq_v_q     <= 1'b0;
            cq_data_q  <= '0;
            eu_q       <= 1'b0;
            el_q       <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            worst_q    <= worst_d;
            err_q      <= err_d;
            en_q       <= en_d;
            rdf_v_q    <= rdf_v_d;
            rdf_tag_q  <= rdf_tag_d;
            rdf_data_q <= rdf_data_d;
            rdf_resp_q <= rdf_resp_d;
            rdf_last_q <= rdf_last_d;
            cq_v_q     <= cq_v_d;
            cq_data_q  <= cq_data_d;
            eu_q       <= eu_d;
            el_q       <= el_d;
        end
    end

    assign bus.rready         = rready;
    assign bus.rdf_push_valid = rdf_v_q;
    assign bus.rdf_push_tag   = rdf_tag_q;
    assign bus.rdf_push_data  = rdf_data_q;
    assign bus.rdf_push_resp  = rdf_resp_q;
    assign bus.rdf_push_last  = rdf_last_q;
    assign bus.cq_push_valid  = cq_v_q;
    assign bus.cq_push_data   = cq_data_q;
    assign err_unexpected     = eu_q;
    assign err_len            = el_q;

`ifdef APB2AXI_RD_STATS_EN
    logic [31:0] sb_q, sb_d;
    logic [15:0] sd_q, sd_d;

    // Beat counter wraps; drop counter saturates.
    always_comb begin
        sb_d = sb_q;
        sd_d = sd_q;
        if (acc) sb_d = sb_q + 32'd1;
        if (drop && sd_q != 16'hFFFF) sd_d = sd_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sb_q <= 32'd0;
            sd_q <= 16'd0;
        end else begin
            sb_q <= sb_d;
            sd_q <= sd_d;
        end
    end

    assign stat_beats = sb_q;
    assign stat_drops = sd_q;
`endif
endmodule

// File: doc/apb2axi_rd_collector.md
Name: apb2axi_rd_collector

Overview:
AXI read-return collector on the AXI clock, sitting directly upstream of the response handler. Accepts AXI R-channel beats and maps RID to tag. Pushes one RDF entry per beat (tag, data, resp, last). On each burst's final beat, pushes one completion entry into the CQ with merged resp, error flag and beat count. Per-tag expected length comes from the AR issue side.

Parameters:
TAG_W, 4, tag width; RID[TAG_W-1:0] is the tag, N_TAG = 2**TAG_W
ID_W, 4, AXI RID width (>= TAG_W)
DATA_W, 64, AXI data width
COMPLETION_W, 16, packed completion width: {tag, is_write, resp[1:0], error, num_beats[7:0]}, MSB first

Ports:
aclk  in  1  AXI clock
areset  in  1  asynchronous active-high reset
ar_issue_valid  in  1  AR accepted on AXI; registers expected length for ar_issue_tag
ar_issue_tag  in  TAG_W  tag of issued AR
ar_issue_len  in  8  AXI ARLEN (beats-1)
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rid  in  ID_W  AXI R id
rdata  in  DATA_W  AXI R data
rresp  in  2  AXI R resp
rlast  in  1  AXI R last
rdf_push_valid  out  1  RDF entry valid
rdf_push_tag  out  TAG_W  entry tag
rdf_push_data  out  DATA_W  entry data
rdf_push_resp  out  2  entry resp
rdf_push_last  out  1  entry is burst's final beat
rdf_push_ready  in  1  RDF has space
cq_push_valid  out  1  completion valid
cq_push_data  out  COMPLETION_W  packed completion (is_write always 0)
cq_push_ready  in  1  CQ has space
err_unexpected  out  1  sticky: beat for non-pending tag, or AR issue for an already-pending tag
err_len  out  1  sticky: RLAST position disagreed with ARLEN

Behaviour:
- Reset: rready=0, rdf_push_valid=0, cq_push_valid=0, err_*=0. All tag tables cleared: pending=0, cnt=0, exp=0, worst=0. Payload outputs=0.
- Per-tag state:
  - pending (1b)
  - exp (8b), loaded from ar_issue_len on issue
  - cnt (8b), beats received
  - worst (2b), numeric max of rresp seen
  - err (1b)
- rready = !rdf_push_valid || rdf_push_ready.
  - Additionally forced to 0 while cq_push_valid && !cq_push_ready.
  - Both terms use current-cycle registered state only; no combinational path from rvalid.
- Beat accept (rvalid && rready), tag t = rid[TAG_W-1:0]:
  - If !pending[t]: beat is dropped (no RDF push, no CQ push) and err_unexpected is set.
  - Otherwise, next cycle rdf_push_valid=1 with {t, rdata, rresp, fin}. Latency is 1 cycle.
  - Output register holds until rdf_push_ready; 1-cycle throughput when ready stays high.
- Final-beat decision: fin = rlast || (cnt[t] == exp[t]).
  - rlast && cnt != exp: set err[t] and err_len.
  - !rlast && cnt == exp: force fin=1, set err[t] and err_len.
  - Any later beats on tag t are then dropped as unexpected.
- On fin:
  - cq_push_valid is asserted in the same cycle as the corresponding rdf_push_valid.
  - cq payload: tag=t, is_write=0, resp=max(worst[t], rresp), error=err[t] | (merged resp >= 2), num_beats=cnt[t]+1.
  - Tag state cleared: pending=0, cnt=0, worst=0, err=0.
  - cq_push_valid is held until cq_push_ready, independent of the RDF handshake.
- Non-fin beat: cnt[t] += 1 and worst[t] is updated. cnt saturates at 255 (unreachable with legal ARLEN).
- AR issue:
  - If !pending: pending=1, exp=len, cnt=0.
  - If pending: ignored and err_unexpected is set.
- Same-cycle AR issue and fin close on the same tag: close is applied first, then the issue loads fresh state. Tag ends pending with cnt=0.
- Same-cycle AR issue and beat on different tags: independent, no priority.
- Interleaved RIDs: fully supported; state is per tag.
- areset mid-burst: all state and outputs clear immediately (asynchronous). In-flight entries are discarded and the tag table is empty after release.

Optional Feature:
APB2AXI_RD_STATS_EN:
- Defined: adds outputs stat_beats[31:0] (accepted beats, wrapping) and stat_drops[15:0] (dropped beats, saturating at 0xFFFF). Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- AR tag 3 len 3; 4 beats OKAY with rlast on 4th, ready=1 -> 4 RDF pushes 1 cycle after each accept, last=1 on the 4th; single CQ entry tag=3 resp=0 error=0 num_beats=4.
- Tags 1 (len 1) and 2 (len 0) interleaved R2,R1,R1; beat 2 of tag 1 has rresp=2 -> CQ tag2 num_beats=1 first, then tag1 resp=2 error=1 num_beats=2.
- rdf_push_ready=0 for 5 cycles during a burst -> rready low after first held beat, no beat lost, data order preserved; CQ held with cq_push_ready=0 -> rready=0 until accepted.
- Beat on never-issued tag 5 -> no RDF/CQ push, err_unexpected=1. Tag 0 len 1 with rlast on beat 1 -> CQ num_beats=1 error=1, err_len=1.
- Tag 7 len 0: AR reissue in the same cycle as its single fin beat -> CQ tag7 num_beats=1; tag 7 left pending with cnt=0, and next beat accepted as first beat.
- areset asserted mid-burst (tag 4, 2 of 4 beats) -> outputs 0 immediately; after release a beat on tag 4 is dropped with err_unexpected=1.
